display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 104 ++++++++++
 tb/tb_display_scan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller.
// Each digit gets a BLANK gap and then a DRIVE window. All outputs are registered.
module display_scan_ctrl #(
    parameter int TICK_MAX  = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Y,
    input  logic [7:0] dig_en,
    input  logic [7:0] dp,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp_n
);

    localparam int CNT_MAX = (TICK_MAX > BLANK_CYC) ? TICK_MAX : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         sel_n;
    logic [7:0]         an_n;
    logic [6:0]         seg_n;
    logic               dpn_n;
    logic               drive_on;

    // Active-low segment decode, seg[6]=a .. seg[0]=g.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        sel_n   = sel;
        case (state)
            BLANK: begin
                if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(TICK_MAX - 1)) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    sel_n   = sel + 3'd1;
                end
            end
            default: begin
                state_n = BLANK;
                cnt_n   = '0;
            end
        endcase

        // Outputs are computed from the next state so they line up with it after the edge.
        drive_on = (state_n == DRIVE) && dig_en[sel_n];
        an_n     = drive_on ? ~(8'h01 << sel_n) : 8'hFF;
        dpn_n    = drive_on ? ~dp[sel_n] : 1'b1;
        seg_n    = hex7(Y);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK;
            cnt   <= '0;
            sel   <= 3'd0;
            an    <= 8'hFF;
            seg   <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
            an    <= an_n;
            seg   <= seg_n;
            dp_n  <= dpn_n;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a refresh-schedule model checked every cycle plus pinned literals.
// Two instances: TICK_MAX=4/BLANK_CYC=2, and TICK_MAX=200/BLANK_CYC=1 for period and minimum-blank checks.
module tb_display_scan_ctrl;

    localparam int TA = 4;
    localparam int BA = 2;
    localparam int TB = 200;
    localparam int BB = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dig_en = 8'hFF;
    logic [7:0] dp = 8'h00;
    logic       use_sweep = 1'b0;
    logic [3:0] y_sweep = 4'h0;

    logic [3:0] ya, yb;
    logic [2:0] sel_a, sel_b;
    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dpn_a, dpn_b;

    assign ya = use_sweep ? y_sweep : {1'b0, sel_a};
    assign yb = {1'b0, sel_b};

    display_scan_ctrl #(.TICK_MAX(TA), .BLANK_CYC(BA)) dut_a (
        .clk(clk), .reset(reset), .Y(ya), .dig_en(dig_en), .dp(dp),
        .sel(sel_a), .an(an_a), .seg(seg_a), .dp_n(dpn_a)
    );

    display_scan_ctrl #(.TICK_MAX(TB), .BLANK_CYC(BB)) dut_b (
        .clk(clk), .reset(reset), .Y(yb), .dig_en(dig_en), .dp(dp),
        .sel(sel_b), .an(an_b), .seg(seg_b), .dp_n(dpn_b)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Position in the refresh frame after k edges since reset release: {sel, an, dp_n}.
    function automatic logic [11:0] scan(input int unsigned k, input int t, input int b,
                                         input logic [7:0] en, input logic [7:0] dpv);
        int unsigned p;
        int          d;
        int          r;
        logic        on;
        logic [7:0]  a;
        logic        n;
        logic [2:0]  s;
        p  = k % (8 * (t + b));
        d  = int'(p) / (t + b);
        r  = int'(p) % (t + b);
        on = (r >= b) && en[d];
        a  = on ? ~(8'h01 << d) : 8'hFF;
        n  = on ? ~dpv[d] : 1'b1;
        s  = d[2:0];
        return {s, a, n};
    endfunction

    int unsigned ka, kb;
    logic [11:0] exp_a, exp_b;
    logic [6:0]  exp_seg_a, exp_seg_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ka        <= 0;
            kb        <= 0;
            exp_a     <= {3'd0, 8'hFF, 1'b1};
            exp_b     <= {3'd0, 8'hFF, 1'b1};
            exp_seg_a <= 7'h7F;
            exp_seg_b <= 7'h7F;
        end else begin
            ka        <= ka + 1;
            kb        <= kb + 1;
            exp_a     <= scan(ka + 1, TA, BA, dig_en, dp);
            exp_b     <= scan(kb + 1, TB, BB, dig_en, dp);
            exp_seg_a <= seg_tab[ya];
            exp_seg_b <= seg_tab[yb];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("a_sel",  32'(sel_a), 32'(exp_a[11:9]));
        chk("a_an",   32'(an_a),  32'(exp_a[8:1]));
        chk("a_dpn",  32'(dpn_a), 32'(exp_a[0]));
        chk("a_seg",  32'(seg_a), 32'(exp_seg_a));
        chk("a_an_onehot", 32'($countones(~an_a) <= 1), 32'd1);
        chk("b_sel",  32'(sel_b), 32'(exp_b[11:9]));
        chk("b_an",   32'(an_b),  32'(exp_b[8:1]));
        chk("b_dpn",  32'(dpn_b), 32'(exp_b[0]));
        chk("b_seg",  32'(seg_b), 32'(exp_seg_b));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first_fe;
        int second_fe;
        logic prev_fe;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_async_sel", 32'(sel_a), 32'd0);
        chk("rst_async_an",  32'(an_a),  32'hFF);
        chk("rst_async_seg", 32'(seg_a), 32'h7F);
        chk("rst_async_dpn", 32'(dpn_a), 32'd1);
        tick();
        tick();
        reset = 1'b0;

        // Full refresh with all digits enabled, Y = sel.
        tick();           chk("p_k1_an", 32'(an_a), 32'hFF);
        tick();           chk("p_k2_an", 32'(an_a), 32'hFE);
                          chk("p_k2_seg", 32'(seg_a), 32'h01);
        repeat (3) tick(); chk("p_k5_an", 32'(an_a), 32'hFE);
        tick();           chk("p_k6_an", 32'(an_a), 32'hFF);
        repeat (2) tick(); chk("p_k8_an", 32'(an_a), 32'hFD);
                          chk("p_k8_seg", 32'(seg_a), 32'h4F);
        repeat (39) tick(); chk("p_k47_an", 32'(an_a), 32'h7F);
        tick();           chk("p_k48_an", 32'(an_a), 32'hFF);
                          chk("p_k48_sel", 32'(sel_a), 32'd0);

        // Decimal point on digit 1 only.
        dp = 8'h02;
        repeat (7) tick(); chk("p_dp_blank", 32'(dpn_a), 32'd1);
        tick();           chk("p_dp_drive", 32'(dpn_a), 32'd0);
        repeat (40) tick();

        // Sparse enable: digits 0 and 2.
        dig_en = 8'h05;
        repeat (2) tick(); chk("p_en_d0", 32'(an_a), 32'hFE);
        repeat (6) tick(); chk("p_en_d1", 32'(an_a), 32'hFF);
                          chk("p_en_d1_sel", 32'(sel_a), 32'd1);
        repeat (6) tick(); chk("p_en_d2", 32'(an_a), 32'hFB);
        repeat (34) tick();

        // Mid-DRIVE enable/dp changes land on the next edge.
        repeat (2) tick(); chk("p_mid_d0", 32'(an_a), 32'hFE);
        dig_en = 8'h04;
        tick();           chk("p_mid_off", 32'(an_a), 32'hFF);
        dig_en = 8'hFF;
        dp = 8'h01;
        tick();           chk("p_mid_on", 32'(an_a), 32'hFE);
                          chk("p_mid_dp", 32'(dpn_a), 32'd0);

        // Segment decode sweep.
        dp = 8'h00;
        dig_en = 8'h01;
        use_sweep = 1'b1;
        for (int i = 0; i < 16; i++) begin
            y_sweep = 4'(i);
            tick();
            chk("p_sweep_seg", 32'(seg_a), 32'(seg_tab[i]));
        end
        use_sweep = 1'b0;
        dig_en = 8'hFF;

        // Reset in the 3rd DRIVE cycle of digit 5.
        for (int i = 0; i < 60 && (ka % 48) != 34; i++) tick();
        chk("p_d5_an",  32'(an_a),  32'hDF);
        chk("p_d5_sel", 32'(sel_a), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_sel", 32'(sel_a), 32'd0);
        chk("rst_mid_an",  32'(an_a),  32'hFF);
        chk("rst_mid_seg", 32'(seg_a), 32'h7F);
        tick();
        reset = 1'b0;

        // Restart timing and refresh period on the long instance.
        first_fe  = -1;
        second_fe = -1;
        prev_fe   = 1'b0;
        for (int i = 1; i <= 3300 && second_fe < 0; i++) begin
            tick();
            if (i == 1) chk("rel_k1_an", 32'(an_a), 32'hFF);
            if (i == 2) chk("rel_k2_an", 32'(an_a), 32'hFE);
            if (an_b == 8'hFE && !prev_fe) begin
                if (first_fe < 0) first_fe = i;
                else second_fe = i;
            end
            prev_fe = (an_b == 8'hFE);
        end
        chk("b_first_drive", 32'(first_fe), 32'd1);
        chk("b_period", 32'(second_fe - first_fe), 32'(8 * (TB + BB)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
